// File: rtl/ll_pkg.sv
// Shared types and default widths for the linked-list operation controller.
// The node layout {next, data} matches the node RAM word format.
package ll_pkg;

  localparam int LL_DATA_WD   = 32;
  localparam int LL_PTR_WD    = 4;
  localparam int LL_NUM_NODES = 15;

  localparam logic [LL_PTR_WD-1:0] NULL_PTR = '1;

  typedef enum logic [1:0] {
    OP_ILLEGAL = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_CLEAR   = 2'b11
  } ll_op_e;

  typedef enum logic [1:0] {
    STS_OK    = 2'b00,
    STS_EMPTY = 2'b01,
    STS_FULL  = 2'b10,
    STS_BADOP = 2'b11
  } ll_status_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH_WR  = 3'd1,
    S_POP_RD   = 3'd2,
    S_POP_WAIT = 3'd3,
    S_CLR      = 3'd4,
    S_RESP     = 3'd5
  } ll_state_e;

  typedef struct packed {
    logic [LL_PTR_WD-1:0]  next;
    logic [LL_DATA_WD-1:0] data;
  } ll_node_t;

endpackage

// File: rtl/ll_free_map.sv
// Node allocation bitmap: one free bit per node, lowest-free encoder,
// allocated-node count and full flag.
module ll_free_map
  import ll_pkg::*;
#(
  parameter int PTR_WD    = LL_PTR_WD,
  parameter int NUM_NODES = LL_NUM_NODES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alloc,
  input  logic              free,
  input  logic [PTR_WD-1:0] free_idx,
  input  logic              clr,
  output logic [PTR_WD-1:0] alloc_idx,
  output logic              full,
  output logic [PTR_WD-1:0] count
);

  logic [NUM_NODES-1:0] free_bits;
  logic                 alloc_ok;
  logic                 free_ok;

  // Descending scan so the last assignment wins: lowest free index.
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_NODES - 1; i >= 0; i--) begin
      if (free_bits[i]) alloc_idx = PTR_WD'(i);
    end
  end

  assign full     = (count == PTR_WD'(NUM_NODES));
  assign alloc_ok = alloc && !full;
  assign free_ok  = free && (free_idx < PTR_WD'(NUM_NODES)) && !free_bits[free_idx];

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      free_bits <= '1;
      count     <= '0;
    end else if (clr) begin
      free_bits <= '1;
      count     <= '0;
    end else begin
      if (alloc_ok) free_bits[alloc_idx] <= 1'b0;
      if (free_ok)  free_bits[free_idx]  <= 1'b1;
      case ({alloc_ok, free_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ll_op_ctrl.sv
// Linked-list operation controller: serves PUSH/POP/CLEAR requests against an
// external node RAM and drives the head-pointer register's update inputs.
module ll_op_ctrl
  import ll_pkg::*;
#(
  parameter int DATA_WD   = LL_DATA_WD,
  parameter int PTR_WD    = LL_PTR_WD,
  parameter int NUM_NODES = LL_NUM_NODES
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [DATA_WD-1:0]        req_data,
  output logic                      resp_valid,
  output logic [1:0]                resp_status,
  output logic [DATA_WD-1:0]        resp_data,
  input  logic [PTR_WD-1:0]         cur_hd_ptr,
  output logic                      upd_hd_ptr,
  output logic                      make_ll_empty,
  output logic [PTR_WD-1:0]         new_hd_ptr,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  output logic [PTR_WD-1:0]         mem_addr,
  output logic [PTR_WD+DATA_WD-1:0] mem_wr_data,
  input  logic [PTR_WD+DATA_WD-1:0] mem_rd_data,
  output logic [PTR_WD-1:0]         ll_count,
  output logic [2:0]                dbg_state
);

  // Request handshake: a request transfers on a clock edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, so exactly one
  // request is in flight. The response is a single-cycle resp_valid pulse with
  // no backpressure, after which IDLE accepts again.

  localparam logic [PTR_WD-1:0] NULL_IDX = '1;

  ll_state_e           state_q, state_d;
  ll_status_e          status_q, acc_status;
  logic [DATA_WD-1:0]  data_q;
  logic [DATA_WD-1:0]  rdata_q;
  logic [PTR_WD-1:0]   pop_idx_q;
  logic [PTR_WD-1:0]   rd_next;
  logic [DATA_WD-1:0]  rd_payload;
  logic                fm_alloc, fm_free, fm_clr, fm_full;
  logic [PTR_WD-1:0]   fm_alloc_idx;

  assign rd_next    = mem_rd_data[DATA_WD +: PTR_WD];
  assign rd_payload = mem_rd_data[DATA_WD-1:0];

  ll_free_map #(
    .PTR_WD    (PTR_WD),
    .NUM_NODES (NUM_NODES)
  ) u_free_map (
    .clk       (clk),
    .reset_n   (reset_n),
    .alloc     (fm_alloc),
    .free      (fm_free),
    .free_idx  (pop_idx_q),
    .clr       (fm_clr),
    .alloc_idx (fm_alloc_idx),
    .full      (fm_full),
    .count     (ll_count)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    acc_status    = STS_OK;
    upd_hd_ptr    = 1'b0;
    make_ll_empty = 1'b0;
    new_hd_ptr    = '0;
    mem_wr_en     = 1'b0;
    mem_rd_en     = 1'b0;
    mem_addr      = '0;
    mem_wr_data   = '0;
    fm_alloc      = 1'b0;
    fm_free       = 1'b0;
    fm_clr        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          case (ll_op_e'(req_op))
            OP_PUSH: begin
              acc_status = fm_full ? STS_FULL : STS_OK;
              state_d    = fm_full ? S_RESP : S_PUSH_WR;
            end
            OP_POP: begin
              acc_status = (cur_hd_ptr == NULL_IDX) ? STS_EMPTY : STS_OK;
              state_d    = (cur_hd_ptr == NULL_IDX) ? S_RESP : S_POP_RD;
            end
            OP_CLEAR: state_d = S_CLR;
            default: begin
              acc_status = STS_BADOP;
              state_d    = S_RESP;
            end
          endcase
        end
      end
      S_PUSH_WR: begin
        mem_wr_en   = 1'b1;
        mem_addr    = fm_alloc_idx;
        mem_wr_data = {cur_hd_ptr, data_q};
        upd_hd_ptr  = 1'b1;
        new_hd_ptr  = fm_alloc_idx;
        fm_alloc    = 1'b1;
        state_d     = S_RESP;
      end
      S_POP_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = cur_hd_ptr;
        state_d   = S_POP_WAIT;
      end
      S_POP_WAIT: begin
        // Popping the last node also forces the head register empty.
        upd_hd_ptr    = 1'b1;
        new_hd_ptr    = rd_next;
        make_ll_empty = (rd_next == NULL_IDX);
        fm_free       = 1'b1;
        state_d       = S_RESP;
      end
      S_CLR: begin
        make_ll_empty = 1'b1;
        fm_clr        = 1'b1;
        state_d       = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      status_q  <= STS_OK;
      data_q    <= '0;
      rdata_q   <= '0;
      pop_idx_q <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        status_q <= acc_status;
        data_q   <= req_data;
        rdata_q  <= '0;
      end
      if (state_q == S_POP_RD)   pop_idx_q <= cur_hd_ptr;
      if (state_q == S_POP_WAIT) rdata_q   <= rd_payload;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_status = resp_valid ? status_q : STS_OK;
  assign resp_data   = resp_valid ? rdata_q : '0;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ll_op_ctrl.sv
// Randomized bench for ll_op_ctrl against a queue-based list model, with a
// behavioural head register and node RAM around the DUT.
module tb_ll_op_ctrl;
  import ll_pkg::*;

  localparam int DW = 32;
  localparam int PW = 4;
  localparam int NN = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [DW-1:0] req_data = '0;
  logic          resp_valid;
  logic [1:0]    resp_status;
  logic [DW-1:0] resp_data;
  logic [PW-1:0] cur_hd_ptr;
  logic          upd_hd_ptr;
  logic          make_ll_empty;
  logic [PW-1:0] new_hd_ptr;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [PW-1:0] mem_addr;
  logic [PW+DW-1:0] mem_wr_data;
  logic [PW+DW-1:0] mem_rd_data;
  logic [PW-1:0] ll_count;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  ll_op_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_data      (req_data),
    .resp_valid    (resp_valid),
    .resp_status   (resp_status),
    .resp_data     (resp_data),
    .cur_hd_ptr    (cur_hd_ptr),
    .upd_hd_ptr    (upd_hd_ptr),
    .make_ll_empty (make_ll_empty),
    .new_hd_ptr    (new_hd_ptr),
    .mem_wr_en     (mem_wr_en),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_rd_data   (mem_rd_data),
    .ll_count      (ll_count),
    .dbg_state     (dbg_state)
  );

  // Environment: head-pointer register and node RAM with one-cycle read.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)            cur_hd_ptr <= 4'hF;
    else if (make_ll_empty) cur_hd_ptr <= 4'hF;
    else if (upd_hd_ptr)    cur_hd_ptr <= new_hd_ptr;
  end

  logic [PW+DW-1:0] ram [16];
  always_ff @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data   <= ram[mem_addr];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: list front = head node.
  int            m_idx[$];
  logic [DW-1:0] m_dat[$];
  logic [NN-1:0] m_used;

  function automatic int lowest_free();
    for (int i = 0; i < NN; i++) if (!m_used[i]) return i;
    return -1;
  endfunction

  // Last observed transaction, kept for directed spot checks.
  int               o_lat, o_wr, o_rd, o_upd, o_mk, o_busy_rdy;
  logic [PW-1:0]    o_addr, o_rdaddr, o_new, o_cnt;
  logic [PW+DW-1:0] o_wdata;
  logic [1:0]       o_st;
  logic [DW-1:0]    o_dat;

  task automatic do_reset();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    m_idx.delete();
    m_dat.delete();
    m_used = '0;
    @(negedge clk);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [DW-1:0] d);
    int            e_lat, e_wr, e_rd, e_upd, e_mk, idx;
    logic [PW-1:0] e_addr, e_rdaddr, e_new, e_hd;
    logic [PW+DW-1:0] e_wdata;
    logic [1:0]    e_st;
    logic [DW-1:0] e_dat;
    bit            got;
    e_wr = 0; e_rd = 0; e_upd = 0; e_mk = 0;
    e_addr = '0; e_rdaddr = '0; e_new = '0; e_wdata = '0; e_dat = '0;
    e_st = STS_OK;
    e_hd = (m_idx.size() != 0) ? 4'(m_idx[0]) : 4'hF;
    case (op)
      2'b01: begin
        if (m_idx.size() == NN) begin
          e_st = STS_FULL; e_lat = 1;
        end else begin
          idx = lowest_free();
          e_wr = 1; e_addr = 4'(idx); e_wdata = {e_hd, d};
          e_upd = 1; e_new = 4'(idx); e_lat = 2;
          m_idx.push_front(idx); m_dat.push_front(d); m_used[idx] = 1'b1;
        end
      end
      2'b10: begin
        if (m_idx.size() == 0) begin
          e_st = STS_EMPTY; e_lat = 1;
        end else begin
          e_rd = 1; e_rdaddr = e_hd; e_upd = 1;
          e_new = (m_idx.size() > 1) ? 4'(m_idx[1]) : 4'hF;
          e_mk = (m_idx.size() == 1) ? 1 : 0;
          e_dat = m_dat[0]; e_lat = 3;
          m_used[m_idx[0]] = 1'b0;
          void'(m_idx.pop_front()); void'(m_dat.pop_front());
        end
      end
      2'b11: begin
        e_mk = 1; e_lat = 2;
        m_idx.delete(); m_dat.delete(); m_used = '0;
      end
      default: begin
        e_st = STS_BADOP; e_lat = 1;
      end
    endcase

    req_valid = 1'b1; req_op = op; req_data = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 2'b00; req_data = $urandom;

    o_wr = 0; o_rd = 0; o_upd = 0; o_mk = 0; o_busy_rdy = 0; o_lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_wr_en)     begin o_wr++; o_addr = mem_addr; o_wdata = mem_wr_data; end
      if (mem_rd_en)     begin o_rd++; o_rdaddr = mem_addr; end
      if (upd_hd_ptr)    begin o_upd++; o_new = new_hd_ptr; end
      if (make_ll_empty) o_mk++;
      if (req_ready)     o_busy_rdy++;
      if (resp_valid) begin
        o_lat = k; o_st = resp_status; o_dat = resp_data; o_cnt = ll_count;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("resp_timeout", 64'(0), 64'(1));
      do_reset();
      return;
    end
    chk("latency", 64'(o_lat), 64'(e_lat));
    chk("status", 64'(o_st), 64'(e_st));
    chk("resp_data", 64'(o_dat), 64'(e_dat));
    chk("ll_count", 64'(o_cnt), 64'(m_idx.size()));
    chk("wr_strobes", 64'(o_wr), 64'(e_wr));
    chk("rd_strobes", 64'(o_rd), 64'(e_rd));
    chk("upd_strobes", 64'(o_upd), 64'(e_upd));
    chk("empty_strobes", 64'(o_mk), 64'(e_mk));
    chk("ready_busy", 64'(o_busy_rdy), 64'(0));
    if (e_wr == 1 && o_wr == 1) begin
      chk("wr_addr", 64'(o_addr), 64'(e_addr));
      chk("wr_data", 64'(o_wdata), 64'(e_wdata));
    end
    if (e_rd == 1 && o_rd == 1) chk("rd_addr", 64'(o_rdaddr), 64'(e_rdaddr));
    if (e_upd == 1 && o_upd == 1) chk("new_hd_ptr", 64'(o_new), 64'(e_new));
    @(negedge clk);
    chk("ready_after", 64'(req_ready), 64'(1));
    chk("resp_pulse", 64'(resp_valid), 64'(0));
  endtask

  initial begin
    int r, hold_resp;
    m_used = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(1));
    chk("rst_resp", 64'({resp_valid, resp_status, resp_data}), 64'(0));
    chk("rst_count", 64'(ll_count), 64'(0));
    chk("rst_strobes", 64'({upd_hd_ptr, make_ll_empty, mem_wr_en, mem_rd_en}), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));

    // Single push into empty list, then LIFO order.
    do_op(2'b01, 32'hA5);
    chk("t2_addr", 64'(o_addr), 64'(0));
    chk("t2_wdata", 64'(o_wdata), {28'h0, 4'hF, 32'hA5});
    do_op(2'b10, 32'h0);
    do_op(2'b01, 32'h11);
    do_op(2'b01, 32'h22);
    do_op(2'b10, 32'h0);
    chk("t3_pop1", 64'(o_dat), 64'(32'h22));
    do_op(2'b10, 32'h0);
    chk("t3_pop2", 64'(o_dat), 64'(32'h11));
    do_op(2'b10, 32'h0);
    chk("t3_empty", 64'(o_st), 64'(STS_EMPTY));

    // Fill, overflow, then reuse of the freed index.
    for (int i = 0; i < NN; i++) do_op(2'b01, $urandom);
    do_op(2'b01, 32'hDEAD);
    chk("t4_full", 64'(o_st), 64'(STS_FULL));
    do_op(2'b10, 32'h0);
    do_op(2'b01, 32'hBEEF);
    chk("t4_reuse", 64'(o_addr), 64'(14));

    // Clear, then allocation restarts at index 0.
    do_op(2'b11, 32'h0);
    for (int i = 0; i < 3; i++) do_op(2'b01, $urandom);
    do_op(2'b11, 32'h0);
    do_op(2'b01, 32'h77);
    chk("t5_alloc0", 64'(o_addr), 64'(0));
    do_op(2'b00, $urandom);
    chk("t6_badop", 64'(o_st), 64'(STS_BADOP));

    // Reset asserted while the POP is waiting on RAM data.
    req_valid = 1'b1; req_op = 2'b10;
    @(posedge clk); #1 req_valid = 1'b0; req_op = 2'b00;
    @(posedge clk); #1;
    chk("t6_in_pop_wait", 64'(dbg_state), 64'(S_POP_WAIT));
    reset_n = 1'b1;
    hold_resp = 0;
    repeat (3) begin @(negedge clk); if (resp_valid) hold_resp++; end
    reset_n = 1'b0;
    m_idx.delete(); m_dat.delete(); m_used = '0;
    repeat (3) begin @(negedge clk); if (resp_valid) hold_resp++; end
    chk("t6_no_resp", 64'(hold_resp), 64'(0));
    chk("t6_count", 64'(ll_count), 64'(0));
    chk("t6_ready", 64'(req_ready), 64'(1));
    do_op(2'b10, 32'h0);
    do_op(2'b01, 32'h5A);

    // Randomized mix, biased towards PUSH so the full boundary is visited.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 39);
      if (r < 22)      do_op(2'b01, $urandom);
      else if (r < 35) do_op(2'b10, $urandom);
      else if (r < 37) do_op(2'b11, $urandom);
      else             do_op(2'b00, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
